mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage MIPS pipeline, between the execute stage and `wb_stage`. It holds one instruction per cycle and waits for the data-SRAM response when EX issued a load/store. It sign/zero-extends and merges load data, and forwards results to decode. It drops in-flight work on exception or ERET flush from WB, discarding late SRAM responses that belong to flushed instructions.

## Interface
- `DISCARD_CNT_W`, 2: width of the stale-response counter.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `es_to_ms_valid` in 1: EX holds a valid instruction for MEM.
- `es_to_ms_bus` in `ES_TO_MS_BUS_WD`: {excp_bvaddr, bd, rt_value, cp0_addr, eret, mtc0, mfc0, excp_valid, excp_execode, mem_req, load_op[2:0], addr_low[1:0], gr_we, dest, alu_result, pc}.
- `ms_allowin` out 1: MEM can accept from EX this cycle.
- `data_sram_data_ok` in 1: one-cycle response strobe; in-order, one per issued request.
- `data_sram_rdata` in 32: response data, valid with `data_ok`.
- `ws_allowin` in 1: WB can accept.
- `ms_to_ws_valid` out 1: MEM output valid.
- `ms_to_ws_bus` out `MS_TO_WS_BUS_WD`: {excp_bvaddr, bd, rt_value, cp0_addr, eret, mtc0, mfc0, excp_valid, excp_execode, gr_we, dest, final_result, pc}.
- `ms_to_ds_fw_bus` out `FW_BUS_WD`: {rf_we, dest, result}.
- `ms_fw_pending` out 1: MEM holds a load whose data is not yet available; decode must stall on a dest match.
- `ms_excp_valid` out 1: `ms_valid && (excp_valid || eret)`; EX must suppress new store requests.
- `ws_excp_valid` in 1: WB is taking an exception (flush).
- `eret_flush` in 1: ERET commits (flush).

## Operation
- Pipeline register: `ms_valid` and bus copy are loaded when `ms_allowin && es_to_ms_valid`. `ms_allowin = !ms_valid || (ms_ready_go && ws_allowin)`.
- `ms_ready_go = !mem_req || excp_valid || rdata_buf_vld || (data_ok && discard_cnt==0)`.
- Response capture: when `data_ok && discard_cnt==0` and MEM holds an outstanding request but cannot hand off (`!ws_allowin`), `data_sram_rdata` goes into `rdata_buf` and `rdata_buf_vld<=1`. The buffer is cleared when the instruction leaves or is flushed.
- Load data source: `rdata_buf_vld ? rdata_buf : data_sram_rdata`.
- Load extension by `load_op` and `addr_low`:
  - LB: sign-extend the selected byte. LBU: zero-extend it.
  - LH: sign-extend the halfword at `addr_low[1]`. LHU: zero-extend it.
  - LW: pass the word through.
  - `final_result` is `alu_result` when the instruction is not a load.
- Flush (`ws_excp_valid || eret_flush`): `ms_valid<=0` next edge.
  - If the flushed entry had `mem_req`, its response has not arrived, and `data_ok` is not asserted this cycle, then `discard_cnt` increments.
- Stale discard: while `discard_cnt!=0`, each `data_ok` decrements the counter and is ignored. A simultaneous increment and decrement leaves the counter unchanged. The counter saturates at its maximum value.
- Forwarding: `rf_we = ms_valid && gr_we && !mfc0`. `ms_fw_pending = ms_valid && gr_we && load && !ms_ready_go`.
- An instruction carrying an exception passes through without waiting for data.

## Timing
- Reset values: `ms_valid`, `ms_to_ws_valid`, `ms_fw_pending`, `ms_excp_valid`, `rdata_buf_vld` and `discard_cnt` are 0. `ms_allowin` is 1. The bus register and `rdata_buf` are 0.
- Minimum latency: 1 cycle, when `data_ok` arrives in the first cycle MEM holds the instruction or no request was made.
- Reset mid-load: all state clears. Responses after reset are not expected.
- A flush wins over a same-cycle accept from EX; the incoming entry is dropped.

## Configuration
- `MS_LWLR_EN` defined:
  - LWL/LWR `load_op` codes merge the aligned word with `rt_value` per `addr_low`, big-to-little byte lanes per MIPS32.
  - `ms_fw_pending` also covers these ops.
- `MS_LWLR_EN` undefined: LWL/LWR codes are treated as LW.

## Structure
- `mycpu.h` holds the `ES_TO_MS_BUS_WD`, `MS_TO_WS_BUS_WD` and `FW_BUS_WD` widths, the bus field order, and the `LOAD_OP_*` encodings.
- One sub-module, `mem_load_align`: combinational extract/extend/merge taking `load_op`, `addr_low`, `rdata` and `rt_value`.

## Test plan
- LB from byte address 0x...3 with rdata 0x80FF_1234: `data_ok` in cycle 1 gives `final_result=0xFFFF_FF80`. LBU in the same situation gives `0x0000_0080`.
- LW with `data_ok` at cycle 3 and `ws_allowin=1`: `ms_fw_pending=1` in cycles 1–2 and `ms_to_ws_valid` rises in cycle 3. The result is the rdata.
- `ws_allowin=0` when `data_ok` carries 0xDEADBEEF: data is buffered. WB accepts 2 cycles later with `final_result=0xDEADBEEF`, and `ms_allowin` stays 0 until then.
- Flush while a load is outstanding, then a new LW issues. The first `data_ok` (0x1111_1111) is discarded with `discard_cnt` going 1→0. The second (0x2222_2222) is delivered.
- Entry with `excp_valid=1`, execode 0x04 and `mem_req=0`: passes in 1 cycle, `ms_excp_valid=1`, and bvaddr is unchanged on the output.
- With `MS_LWLR_EN`, LWL at `addr_low=1` with rt=0xAABBCCDD and rdata=0x11223344 gives the MIPS32-defined merge. Without the macro, the result is 0x11223344.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared types for the MEM pipeline stage. It holds the EX->MEM,
//               MEM->WB and MEM->ID forwarding bus layouts, their widths, and
//               the load_op encodings. Bus field order runs MSB first, in the
//               order the fields are listed in each struct.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  typedef enum logic [2:0] {
    LOAD_OP_NONE = 3'd0,
    LOAD_OP_LB   = 3'd1,
    LOAD_OP_LBU  = 3'd2,
    LOAD_OP_LH   = 3'd3,
    LOAD_OP_LHU  = 3'd4,
    LOAD_OP_LW   = 3'd5,
    LOAD_OP_LWL  = 3'd6,
    LOAD_OP_LWR  = 3'd7
  } load_op_e;

  typedef struct packed {
    logic [31:0] excp_bvaddr;
    logic        bd;
    logic [31:0] rt_value;
    logic [7:0]  cp0_addr;
    logic        eret;
    logic        mtc0;
    logic        mfc0;
    logic        excp_valid;
    logic [4:0]  excp_execode;
    logic        mem_req;
    load_op_e    load_op;
    logic [1:0]  addr_low;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

  typedef struct packed {
    logic [31:0] excp_bvaddr;
    logic        bd;
    logic [31:0] rt_value;
    logic [7:0]  cp0_addr;
    logic        eret;
    logic        mtc0;
    logic        mfc0;
    logic        excp_valid;
    logic [4:0]  excp_execode;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] result;
  } fw_t;

  localparam int ES_TO_MS_BUS_WD = $bits(es_to_ms_t);
  localparam int MS_TO_WS_BUS_WD = $bits(ms_to_ws_t);
  localparam int FW_BUS_WD       = $bits(fw_t);

  function automatic logic is_load(input load_op_e op);
    return op != LOAD_OP_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_align
// Description : Combinational load-data extract / extend / merge.
//               The build macro MS_LWLR_EN enables the LWL/LWR word merge with
//               rt_value. When MS_LWLR_EN is not defined, those codes behave
//               as LW.
// Ports       : load_op  - load type
//               addr_low - byte offset within the word
//               rdata    - aligned 32-bit word from the data SRAM
//               rt_value - old rt contents (LWL/LWR merge source)
//               result   - value to be written back
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_align
  import mem_stage_pkg::*;
(
  input  load_op_e    load_op,
  input  logic [1:0]  addr_low,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_value,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_low, 3'b000} +: 8];
    half_sel = addr_low[1] ? rdata[31:16] : rdata[15:0];
  end

`ifdef MS_LWLR_EN
  // In little-endian byte lanes, LWL fills the upper bytes of rt from the low
  // end of the word. LWR fills the lower bytes of rt from the high end.
  logic [31:0] lwl_word;
  logic [31:0] lwr_word;

  always_comb begin
    lwl_word = rdata;
    lwr_word = rdata;
    case (addr_low)
      2'd0: begin
        lwl_word = {rdata[7:0],  rt_value[23:0]};
        lwr_word = rdata;
      end
      2'd1: begin
        lwl_word = {rdata[15:0], rt_value[15:0]};
        lwr_word = {rt_value[31:24], rdata[31:8]};
      end
      2'd2: begin
        lwl_word = {rdata[23:0], rt_value[7:0]};
        lwr_word = {rt_value[31:16], rdata[31:16]};
      end
      default: begin
        lwl_word = rdata;
        lwr_word = {rt_value[31:8], rdata[31:24]};
      end
    endcase
  end
`else
  logic unused_rt;
  assign unused_rt = ^rt_value;
`endif

  always_comb begin
    result = rdata;
    case (load_op)
      LOAD_OP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      LOAD_OP_LBU: result = {24'd0, byte_sel};
      LOAD_OP_LH:  result = {{16{half_sel[15]}}, half_sel};
      LOAD_OP_LHU: result = {16'd0, half_sel};
`ifdef MS_LWLR_EN
      LOAD_OP_LWL: result = lwl_word;
      LOAD_OP_LWR: result = lwr_word;
`endif
      default:     result = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MIPS pipeline MEM stage. It holds one instruction and waits
//               for the in-order data-SRAM response. It extends or merges the
//               load data and forwards the result to decode. On a WB flush it
//               drops the in-flight work, and it counts and discards SRAM
//               responses that belong to the flushed instructions.
//               The build macro MS_LWLR_EN (in mem_load_align) enables LWL/LWR.
// Ports       : clk, reset (async, active-high)
//               es_to_ms_valid/bus, ms_allowin  - handshake from EX
//               data_sram_data_ok/rdata         - SRAM response strobe/data
//               ws_allowin, ms_to_ws_valid/bus  - handshake to WB
//               ms_to_ds_fw_bus, ms_fw_pending  - forwarding/stall to ID
//               ms_excp_valid                   - blocks stores in EX
//               ws_excp_valid, eret_flush       - pipeline flush from WB
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DISCARD_CNT_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_allowin,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [FW_BUS_WD-1:0]       ms_to_ds_fw_bus,
  output logic                       ms_fw_pending,
  output logic                       ms_excp_valid,
  input  logic                       ws_excp_valid,
  input  logic                       eret_flush
);

  logic                     ms_valid;
  es_to_ms_t                ms_bus;
  logic [31:0]              rdata_buf;
  logic                     rdata_buf_vld;
  logic [DISCARD_CNT_W-1:0] discard_cnt;

  logic        flush;
  logic        resp_live;
  logic        req_pending;
  logic        ms_ready_go;
  logic        handoff;
  logic        cnt_inc;
  logic        cnt_dec;
  logic        load_inst;
  logic [31:0] load_data;
  logic [31:0] load_result;
  logic [31:0] final_result;
  ms_to_ws_t   ws_out;
  fw_t         fw_out;

  assign flush     = ws_excp_valid || eret_flush;
  // Only a response that arrives while no stale responses are owed belongs
  // to the instruction held here.
  assign resp_live = data_sram_data_ok && (discard_cnt == '0);
  // An excepting instruction never issued its request, so it owes no response.
  assign req_pending = ms_bus.mem_req && !ms_bus.excp_valid && !rdata_buf_vld;

  assign ms_ready_go    = !ms_bus.mem_req || ms_bus.excp_valid || rdata_buf_vld || resp_live;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign handoff        = ms_to_ws_valid && ws_allowin;

  // Pipeline register; a flush also kills a same-cycle accept from EX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid <= 1'b0;
      ms_bus   <= '0;
    end else begin
      if (flush) begin
        ms_valid <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      if (!flush && ms_allowin && es_to_ms_valid) begin
        ms_bus <= es_to_ms_t'(es_to_ms_bus);
      end
    end
  end

  // Hold a response that arrives while WB is stalled, since the SRAM
  // presents it for only one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_buf     <= '0;
      rdata_buf_vld <= 1'b0;
    end else if (flush || handoff) begin
      rdata_buf_vld <= 1'b0;
    end else if (ms_valid && req_pending && resp_live && !ws_allowin) begin
      rdata_buf     <= data_sram_rdata;
      rdata_buf_vld <= 1'b1;
    end
  end

  // Count the responses still owed to flushed instructions.
  assign cnt_inc = flush && ms_valid && req_pending && !resp_live;
  assign cnt_dec = data_sram_data_ok && (discard_cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      discard_cnt <= '0;
    end else if (cnt_inc && !cnt_dec) begin
      if (discard_cnt != {DISCARD_CNT_W{1'b1}}) begin
        discard_cnt <= discard_cnt + DISCARD_CNT_W'(1);
      end
    end else if (cnt_dec && !cnt_inc) begin
      discard_cnt <= discard_cnt - DISCARD_CNT_W'(1);
    end
  end

  assign load_data = rdata_buf_vld ? rdata_buf : data_sram_rdata;
  assign load_inst = is_load(ms_bus.load_op);

  mem_load_align u_load_align (
    .load_op  (ms_bus.load_op),
    .addr_low (ms_bus.addr_low),
    .rdata    (load_data),
    .rt_value (ms_bus.rt_value),
    .result   (load_result)
  );

  assign final_result = load_inst ? load_result : ms_bus.alu_result;

  always_comb begin
    ws_out              = '0;
    ws_out.excp_bvaddr  = ms_bus.excp_bvaddr;
    ws_out.bd           = ms_bus.bd;
    ws_out.rt_value     = ms_bus.rt_value;
    ws_out.cp0_addr     = ms_bus.cp0_addr;
    ws_out.eret         = ms_bus.eret;
    ws_out.mtc0         = ms_bus.mtc0;
    ws_out.mfc0         = ms_bus.mfc0;
    ws_out.excp_valid   = ms_bus.excp_valid;
    ws_out.excp_execode = ms_bus.excp_execode;
    ws_out.gr_we        = ms_bus.gr_we;
    ws_out.dest         = ms_bus.dest;
    ws_out.final_result = final_result;
    ws_out.pc           = ms_bus.pc;
  end

  assign ms_to_ws_bus = ws_out;

  // The value of an mfc0 is only known in WB, so it is not forwarded from here.
  always_comb begin
    fw_out        = '0;
    fw_out.rf_we  = ms_valid && ms_bus.gr_we && !ms_bus.mfc0;
    fw_out.dest   = ms_bus.dest;
    fw_out.result = final_result;
  end

  assign ms_to_ds_fw_bus = fw_out;
  assign ms_fw_pending   = ms_valid && ms_bus.gr_we && load_inst && !ms_ready_go;
  assign ms_excp_valid   = ms_valid && (ms_bus.excp_valid || ms_bus.eret);

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed self-checking bench for mem_stage. Expected WB bus
//               words are queued when stimulus is driven and compared when
//               the stage hands an instruction to WB.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_allowin;
  logic                       data_sram_data_ok;
  logic [31:0]                data_sram_rdata;
  logic                       ws_allowin;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [FW_BUS_WD-1:0]       ms_to_ds_fw_bus;
  logic                       ms_fw_pending;
  logic                       ms_excp_valid;
  logic                       ws_excp_valid;
  logic                       eret_flush;

  int n_checks = 0;
  int n_fail   = 0;
  logic [MS_TO_WS_BUS_WD-1:0] exp_q[$];
  logic [MS_TO_WS_BUS_WD-1:0] exp_bus;

  always #5 clk = ~clk;

  mem_stage #(.DISCARD_CNT_W(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_allowin        (ms_allowin),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_to_ds_fw_bus   (ms_to_ds_fw_bus),
    .ms_fw_pending     (ms_fw_pending),
    .ms_excp_valid     (ms_excp_valid),
    .ws_excp_valid     (ws_excp_valid),
    .eret_flush        (eret_flush)
  );

  typedef struct {
    logic [31:0] bvaddr;
    logic        bd;
    logic [31:0] rt;
    logic [7:0]  cp0;
    logic        eret, mtc0, mfc0, excp;
    logic [4:0]  code;
    logic        mem_req;
    logic [2:0]  lop;
    logic [1:0]  al;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu, pc;
  } ent_t;

  function automatic logic [ES_TO_MS_BUS_WD-1:0] pack_es(input ent_t e);
    return {e.bvaddr, e.bd, e.rt, e.cp0, e.eret, e.mtc0, e.mfc0, e.excp, e.code,
            e.mem_req, e.lop, e.al, e.gr_we, e.dest, e.alu, e.pc};
  endfunction

  function automatic logic [MS_TO_WS_BUS_WD-1:0] pack_ms(input ent_t e, input logic [31:0] res);
    return {e.bvaddr, e.bd, e.rt, e.cp0, e.eret, e.mtc0, e.mfc0, e.excp, e.code,
            e.gr_we, e.dest, res, e.pc};
  endfunction

  function automatic ent_t mk(input logic [31:0] pc, input logic [2:0] lop,
                              input logic [1:0] al, input logic mem_req);
    ent_t e;
    e.bvaddr = 32'hB000_0000 | pc;
    e.bd     = 1'b0;
    e.rt     = 32'hAABB_CCDD;
    e.cp0    = 8'h61;
    e.eret   = 1'b0;
    e.mtc0   = 1'b0;
    e.mfc0   = 1'b0;
    e.excp   = 1'b0;
    e.code   = 5'd0;
    e.mem_req = mem_req;
    e.lop    = lop;
    e.al     = al;
    e.gr_we  = 1'b1;
    e.dest   = 5'd9;
    e.alu    = 32'h1000_0000 | pc;
    e.pc     = pc;
    return e;
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic checkv(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every instruction WB accepts (outside a flush) must match
  // the next queued expectation.
  always @(negedge clk) begin
    if (!reset && ms_to_ws_valid && ws_allowin && !ws_excp_valid && !eret_flush) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_output: observed=%0h expected=none", ms_to_ws_bus);
      end
      if (exp_q.size() != 0) begin
        exp_bus = exp_q.pop_front();
        checkv("ws_bus", 160'(ms_to_ws_bus), 160'(exp_bus));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input ent_t e);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = pack_es(e);
    @(negedge clk);
    check1("accept_allowin", ms_allowin, 1'b1);
    tick();
    es_to_ms_valid = 1'b0;
    es_to_ms_bus   = '0;
  endtask

  task automatic load_one(input ent_t e, input logic [31:0] rd, input logic [31:0] res);
    issue(e);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    exp_q.push_back(pack_ms(e, res));
    @(negedge clk);
    check1("one_cycle_valid", ms_to_ws_valid, 1'b1);
    tick();
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    ent_t e, e2;
    logic [31:0] lwl_exp, lwr_exp;

    reset = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    ws_allowin = 1'b1;
    ws_excp_valid = 1'b0;
    eret_flush = 1'b0;

    // Reset state
    tick();
    @(negedge clk);
    check1("rst_allowin", ms_allowin, 1'b1);
    check1("rst_to_ws_valid", ms_to_ws_valid, 1'b0);
    check1("rst_fw_pending", ms_fw_pending, 1'b0);
    check1("rst_excp_valid", ms_excp_valid, 1'b0);
    checkv("rst_ws_bus", 160'(ms_to_ws_bus), 160'd0);
    checkv("rst_fw_bus", 160'(ms_to_ds_fw_bus), 160'd0);
    checkv("rst_discard", 160'(dut.discard_cnt), 160'd0);
    tick();
    reset = 1'b0;

    // LB / LBU from byte 3, single-cycle response
    load_one(mk(32'h100, LOAD_OP_LB,  2'd3, 1'b1), 32'h80FF_1234, 32'hFFFF_FF80);
    load_one(mk(32'h104, LOAD_OP_LBU, 2'd3, 1'b1), 32'h80FF_1234, 32'h0000_0080);

    // LW with response in cycle 3
    e = mk(32'h108, LOAD_OP_LW, 2'd0, 1'b1);
    issue(e);
    @(negedge clk);
    check1("lw_c1_pending", ms_fw_pending, 1'b1);
    check1("lw_c1_valid", ms_to_ws_valid, 1'b0);
    check1("lw_c1_allowin", ms_allowin, 1'b0);
    tick();
    @(negedge clk);
    check1("lw_c2_pending", ms_fw_pending, 1'b1);
    check1("lw_c2_valid", ms_to_ws_valid, 1'b0);
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hCAFE_F00D;
    exp_q.push_back(pack_ms(e, 32'hCAFE_F00D));
    @(negedge clk);
    check1("lw_c3_valid", ms_to_ws_valid, 1'b1);
    check1("lw_c3_pending", ms_fw_pending, 1'b0);
    checkv("lw_c3_fw", 160'(ms_to_ds_fw_bus), 160'({1'b1, 5'd9, 32'hCAFE_F00D}));
    tick();
    data_sram_data_ok = 1'b0;

    // Response arrives while WB is stalled: it is buffered
    e = mk(32'h10C, LOAD_OP_LW, 2'd0, 1'b1);
    issue(e);
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check1("buf_c1_allowin", ms_allowin, 1'b0);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    check1("buf_c2_allowin", ms_allowin, 1'b0);
    check1("buf_c2_valid", ms_to_ws_valid, 1'b1);
    tick();
    ws_allowin = 1'b1;
    exp_q.push_back(pack_ms(e, 32'hDEAD_BEEF));
    @(negedge clk);
    check1("buf_c3_allowin", ms_allowin, 1'b1);
    tick();

    // Flush with a load outstanding; its response is discarded
    issue(mk(32'h200, LOAD_OP_LW, 2'd0, 1'b1));
    ws_excp_valid = 1'b1;
    @(negedge clk);
    tick();
    ws_excp_valid = 1'b0;
    e2 = mk(32'h204, LOAD_OP_LW, 2'd0, 1'b1);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = pack_es(e2);
    @(negedge clk);
    checkv("flush_discard_1", 160'(dut.discard_cnt), 160'd1);
    check1("flush_allowin", ms_allowin, 1'b1);
    tick();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1111_1111;
    @(negedge clk);
    check1("stale_valid", ms_to_ws_valid, 1'b0);
    check1("stale_pending", ms_fw_pending, 1'b1);
    tick();
    data_sram_rdata = 32'h2222_2222;
    exp_q.push_back(pack_ms(e2, 32'h2222_2222));
    @(negedge clk);
    checkv("flush_discard_0", 160'(dut.discard_cnt), 160'd0);
    check1("fresh_valid", ms_to_ws_valid, 1'b1);
    tick();
    data_sram_data_ok = 1'b0;

    // Increment and decrement in the same cycle keep the counter
    issue(mk(32'h300, LOAD_OP_LW, 2'd0, 1'b1));
    eret_flush = 1'b1;
    @(negedge clk);
    tick();
    eret_flush = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = pack_es(mk(32'h304, LOAD_OP_LW, 2'd0, 1'b1));
    @(negedge clk);
    checkv("incdec_pre", 160'(dut.discard_cnt), 160'd1);
    tick();
    es_to_ms_valid = 1'b0;
    ws_excp_valid = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h3333_3333;
    @(negedge clk);
    tick();
    ws_excp_valid = 1'b0;
    @(negedge clk);
    checkv("incdec_hold", 160'(dut.discard_cnt), 160'd1);
    tick();
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    checkv("incdec_drain", 160'(dut.discard_cnt), 160'd0);
    tick();

    // A flush wins over a same-cycle accept
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = pack_es(mk(32'h400, LOAD_OP_NONE, 2'd0, 1'b0));
    ws_excp_valid = 1'b1;
    @(negedge clk);
    tick();
    es_to_ms_valid = 1'b0;
    ws_excp_valid = 1'b0;
    @(negedge clk);
    check1("flush_drop_valid", ms_to_ws_valid, 1'b0);
    tick();

    // Exception entry passes straight through
    e = mk(32'h500, LOAD_OP_NONE, 2'd0, 1'b0);
    e.excp = 1'b1;
    e.code = 5'h04;
    e.bvaddr = 32'h1234_5678;
    issue(e);
    exp_q.push_back(pack_ms(e, e.alu));
    @(negedge clk);
    check1("excp_ms_excp_valid", ms_excp_valid, 1'b1);
    check1("excp_valid_out", ms_to_ws_valid, 1'b1);
    tick();

    // Halfword extension at addr_low 2
    load_one(mk(32'h600, LOAD_OP_LH,  2'd2, 1'b1), 32'h8001_7FFF, 32'hFFFF_8001);
    load_one(mk(32'h604, LOAD_OP_LHU, 2'd2, 1'b1), 32'h8001_7FFF, 32'h0000_8001);

    // LWL / LWR at addr_low 1
`ifdef MS_LWLR_EN
    lwl_exp = 32'h3344_CCDD;
    lwr_exp = 32'hAA11_2233;
`else
    lwl_exp = 32'h1122_3344;
    lwr_exp = 32'h1122_3344;
`endif
    load_one(mk(32'h700, LOAD_OP_LWL, 2'd1, 1'b1), 32'h1122_3344, lwl_exp);
    load_one(mk(32'h704, LOAD_OP_LWR, 2'd1, 1'b1), 32'h1122_3344, lwr_exp);

    // mfc0 is not forwarded; the ALU result goes to WB
    e = mk(32'h800, LOAD_OP_NONE, 2'd0, 1'b0);
    e.mfc0 = 1'b1;
    issue(e);
    exp_q.push_back(pack_ms(e, e.alu));
    @(negedge clk);
    checkv("mfc0_fw", 160'(ms_to_ds_fw_bus), 160'({1'b0, 5'd9, e.alu}));
    tick();

    tick();
    checkv("queue_drained", 160'(exp_q.size()), 160'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
